// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses 0..NUM_REGS-1 and streams each word with its address over valid/ready.
// Optional trailing XOR checksum word enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEND, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            raddr_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raddr_q <= raddr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raddr_d = raddr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);

        // abort outranks any accept; read address and output payload keep their last values
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ADDR;
                        idx_d   = '0;
                        raddr_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                S_ADDR: begin
                    data_d  = rf_rdata;
                    addr_d  = idx_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_d  = csum_q ^ data_q;
`endif
                        if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            raddr_d = idx_q + ADDR_W'(1);
                            state_d = S_ADDR;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                // first CSUM cycle loads the word, mirroring ADDR; then hold until accepted
                S_CSUM: begin
                    if (!valid_q) begin
                        data_d  = csum_q;
                        addr_d  = '1;
                        valid_d = 1'b1;
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign rf_raddr  = raddr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus pushes expected words/done times, a monitor pops and compares.
module tb_regfile_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int DONE_OFF = 2 * N + 2;
`else
    localparam int DONE_OFF = 2 * N;
`endif

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic          out_valid, busy, done;
    logic [AW-1:0] rf_raddr, out_addr;
    logic [DW-1:0] rf_rdata, out_data;
    logic [DW-1:0] rf [N];

    int unsigned   cyc = 0;
    int            errors = 0;
    int            checks = 0;
    int            ready_mode = 0;
    logic [AW+DW-1:0] exp_q [$];
    int unsigned      done_q [$];
    logic [DW-1:0]    exp_csum;

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rf_rdata = rf[rf_raddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: accepted words, hold stability and done pulses
    logic             hold_v = 1'b0;
    logic [AW+DW-1:0] hold_w;
    logic [AW+DW-1:0] mon_e;
    int unsigned      mon_d;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("hold_stable", {out_valid, out_addr, out_data}, {1'b1, hold_w});
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got addr %h data %h expected no word", out_addr, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word", {out_addr, out_data}, mon_e);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_drained", exp_q.size(), 0);
                    if (mon_d != 0) chk("done_cycle", cyc, mon_d);
                end
            end
            hold_v = out_valid && !out_ready && !abort;
            hold_w = {out_addr, out_data};
        end
    end

    task automatic begin_dump();
        exp_csum = '0;
    endtask

    task automatic push_word(input int a, input logic [DW-1:0] d);
        exp_q.push_back({AW'(a), d});
        exp_csum = exp_csum ^ d;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_word(i, rf[i]);
    endtask

    task automatic end_dump();
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back({{AW{1'b1}}, exp_csum});
`endif
    endtask

    // dmode: 0 no done expected, 1 done expected (untimed), 2 done expected at start edge + DONE_OFF
    task automatic pulse_start(input int dmode);
        @(posedge clk);
        #1 start = 1'b1;
        if (dmode == 2) done_q.push_back(cyc + 1 + DONE_OFF);
        else if (dmode == 1) done_q.push_back(0);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_word(input int a);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_addr == AW'(a)) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_word: addr %0d not presented, required within 300 cycles", a);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen, required within 400 cycles");
        end
        @(posedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = i * 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // 1: full dump, ready held high, timing
        ready_mode = 0;
        begin_dump(); push_range(0, N - 1); end_dump();
        pulse_start(2);
        chk("busy_at_start", busy, 1);
        chk("valid_at_start", out_valid, 0);
        @(posedge clk);
        #1;
        chk("first_valid", out_valid, 1);
        chk("first_addr", out_addr, 0);
        wait_done();

        // 2: backpressure, ready high 1 of 3 cycles
        for (int i = 0; i < N; i++) rf[i] = 32'hA5C3_0000 + i * 32'h0000_0101;
        ready_mode = 1;
        begin_dump(); push_range(0, N - 1); end_dump();
        pulse_start(1);
        wait_done();
        ready_mode = 0;

        // 3: start re-pulsed mid-dump, plus writer update ahead of its read
        for (int i = 0; i < N; i++) rf[i] = i * 32'h1111_1111;
        begin_dump(); push_range(0, 19); push_word(20, 32'hCAFE_F00D); push_range(21, N - 1); end_dump();
        pulse_start(2);
        wait_word(10);
        start = 1'b1;
        rf[20] = 32'hCAFE_F00D;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        rf[20] = 20 * 32'h1111_1111;

        // 4: abort during SEND of word 5, then a fresh dump from address 0
        begin_dump(); push_range(0, 4);
        pulse_start(0);
        wait_word(5);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_raddr_kept", rf_raddr, 5);
        chk("abort_addr_kept", out_addr, 5);
        chk("abort_words", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        begin_dump(); push_range(0, N - 1); end_dump();
        pulse_start(2);
        wait_done();

        // 5: reset asserted while word 20 is presented
        begin_dump(); push_range(0, 19);
        pulse_start(0);
        wait_word(20);
        reset = 1'b1;
        #1;
        chk("mid_rst_raddr", rf_raddr, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_words", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

`ifdef REGDUMP_CHECKSUM_EN
        // 6: checksum word values
        for (int i = 0; i < N; i++) rf[i] = i;
        begin_dump(); push_range(0, N - 1);
        exp_q.push_back({5'h1F, 32'h0000_0000});
        pulse_start(2);
        wait_done();
        for (int i = 0; i < N; i++) rf[i] = '0;
        rf[0] = 32'hDEAD_BEEF;
        begin_dump(); push_range(0, N - 1);
        exp_q.push_back({5'h1F, 32'hDEAD_BEEF});
        pulse_start(2);
        wait_done();
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
